// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch front end.
// Holds the reset PC, the NOP encoding and the fetch entry bundle.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push/pop/flush and an occupancy count.
// Ports: push_i/data_i write, pop_i/data_o read head, flush_i empties,
// valid_o/full_o/count_o report occupancy. All outputs are registered state.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type T       = fetch_entry_t,
    parameter T    RST_VAL = '0,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output T              data_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    T              mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          pop_ok;

    // A pop on an empty FIFO is ignored.
    assign pop_ok = pop_i && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (flush_i) begin
            rd_q  <= wr_q;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            unique case ({push_i, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;

`ifndef SYNTHESIS
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && !pop_i && !flush_i)
    );
    a_count_max: assert property (
        @(posedge clk) disable iff (!rst_n)
        cnt_q <= CW'(DEPTH)
    );
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches from imem, queues {pc, instr}.
// Ports: imem_addr_o/imem_instr_i memory side, halt_i/redirect_* control,
// instr_o/pc_o/valid_o/ready_i decode handshake, count_o queue occupancy.
module instr_fetch
    import core_pkg::*;
#(
    parameter int              DATA_WIDTH = 32,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int             CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    input  logic                  halt_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CW-1:0]         count_o
);

    localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, instr: NOP_INSTR};

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  head_valid;
    fetch_entry_t          wr_entry;
    fetch_entry_t          head;
    logic                  unused_lo;

    // Low target bits are dropped when aligning a redirect.
    assign unused_lo = ^redirect_pc_i[1:0];

    assign pop  = head_valid && ready_i;
    assign push = !redirect_i && !halt_i && (!full || pop);

    assign wr_entry = '{pc: pc_q, instr: imem_instr_i};

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            redirect_i: pc_d = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            push:       pc_d = pc_q + DATA_WIDTH'(4);
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .T       (fetch_entry_t),
        .RST_VAL (RST_ENTRY)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_o  (head),
        .valid_o (head_valid),
        .full_o  (full),
        .count_o (count_o)
    );

    assign imem_addr_o = pc_q;
    assign valid_o     = head_valid;
    // An empty queue shows a NOP; pc_o keeps the last head slot's PC.
    assign instr_o     = head_valid ? head.instr : NOP_INSTR;
    assign pc_o        = head.pc;

`ifndef SYNTHESIS
    a_pc_aligned: assert property (
        @(posedge clk) disable iff (!rst_n)
        pc_q[1:0] == 2'b00
    );
    a_count_le_depth: assert property (
        @(posedge clk) disable iff (!rst_n)
        count_o <= CW'(FIFO_DEPTH)
    );
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized and directed bench for instr_fetch against a queue model.
// Model: list of pending {pc, instr} plus the next fetch address.
module tb_instr_fetch;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        halt_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [1:0]  count_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc = 32'h0;
    bit          m_pop;
    int          m_size;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a < 32'd40) begin
            case (a[5:2])
                4'd0: return 32'h0010_0093;
                4'd1: return 32'h0020_0113;
                4'd2: return 32'h0020_81b3;
                4'd3: return 32'h0030_8233;
                4'd4: return 32'h00a2_7293;
                4'd5: return 32'h0050_2023;
                4'd6: return 32'h0000_2303;
                4'd7: return 32'h0062_8463;
                4'd8: return 32'h0000_006f;
                default: return 32'h0000_0013;
            endcase
        end
        return a ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_instr_i = mem_word(imem_addr_o);

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .halt_i        (halt_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .count_o       (count_o)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one fetch step per clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mpc = 32'h0;
        end else begin
            m_size = mq.size();
            m_pop  = (m_size != 0) && ready_i;
            if (redirect_i) begin
                mq.delete();
                mpc = redirect_pc_i & ~32'h3;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (!halt_i && (m_size < DEPTH || m_pop)) begin
                    mq.push_back('{pc: mpc, instr: mem_word(mpc)});
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    // Compare every cycle, mid-period.
    always @(negedge clk) begin
        chk("valid", 32'(valid_o), 32'(mq.size() != 0));
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("imem_addr", imem_addr_o, mpc);
        if (mq.size() != 0) begin
            chk("pc_o", pc_o, mq[0].pc);
            chk("instr_o", instr_o, mq[0].instr);
        end else begin
            chk("instr_nop", instr_o, NOP);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ready_i = 1'b0;
        halt_i = 1'b0;
        redirect_i = 1'b0;
        repeat (2) step();
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_count", 32'(count_o), 32'h0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_addr", imem_addr_o, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: streaming from reset
        do_reset();
        ready_i = 1'b1;
        step();
        chk("t1_valid", 32'(valid_o), 32'h1);
        chk("t1_pc0", pc_o, 32'h0);
        chk("t1_i0", instr_o, 32'h0010_0093);
        step();
        chk("t1_pc1", pc_o, 32'h4);
        chk("t1_i1", instr_o, 32'h0020_0113);
        step();
        chk("t1_pc2", pc_o, 32'h8);
        chk("t1_i2", instr_o, 32'h0020_81b3);

        // 2: backpressure saturates at depth
        do_reset();
        repeat (5) step();
        chk("t2_count", 32'(count_o), 32'd2);
        chk("t2_addr", imem_addr_o, 32'h8);
        chk("t2_head", pc_o, 32'h0);
        ready_i = 1'b1;
        step();
        chk("t2_pc4", pc_o, 32'h4);
        step();
        chk("t2_pc8", pc_o, 32'h8);

        // 3: redirect while full
        ready_i = 1'b0;
        repeat (3) step();
        chk("t3_full", 32'(count_o), 32'd2);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h20;
        step();
        redirect_i = 1'b0;
        chk("t3_count", 32'(count_o), 32'd0);
        chk("t3_valid", 32'(valid_o), 32'h0);
        chk("t3_addr", imem_addr_o, 32'h20);
        ready_i = 1'b1;
        step();
        chk("t3_pc", pc_o, 32'h20);

        // 4: misaligned target
        redirect_i = 1'b1;
        redirect_pc_i = 32'h13;
        step();
        redirect_i = 1'b0;
        step();
        chk("t4_pc", pc_o, 32'h10);
        chk("t4_instr", instr_o, 32'h00a2_7293);

        // 5: address wrap
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        step();
        chk("t5_top", pc_o, 32'hFFFF_FFFC);
        step();
        chk("t5_wrap", pc_o, 32'h0);
        chk("t5_winstr", instr_o, 32'h0010_0093);

        // 6: halt drains, then async reset mid-drain
        ready_i = 1'b0;
        repeat (3) step();
        chk("t6_full", 32'(count_o), 32'd2);
        halt_i = 1'b1;
        ready_i = 1'b1;
        step();
        chk("t6_c1", 32'(count_o), 32'd1);
        step();
        chk("t6_empty", 32'(valid_o), 32'h0);
        chk("t6_frz", imem_addr_o, 32'h8);
        step();
        chk("t6_frz2", imem_addr_o, 32'h8);
        halt_i = 1'b0;
        ready_i = 1'b0;
        repeat (2) step();
        halt_i = 1'b1;
        ready_i = 1'b1;
        step();
        chk("t6_c1b", 32'(count_o), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rvalid", 32'(valid_o), 32'h0);
        chk("t6_rcount", 32'(count_o), 32'h0);
        chk("t6_raddr", imem_addr_o, 32'h0);
        chk("t6_rpc", pc_o, 32'h0);
        halt_i = 1'b0;
        step();
        rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            ready_i    = ($urandom_range(0, 9) < 7);
            halt_i     = ($urandom_range(0, 99) < 12);
            redirect_i = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0: redirect_pc_i = $urandom;
                1: redirect_pc_i = 32'($urandom_range(0, 60));
                2: redirect_pc_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: redirect_pc_i = 32'($urandom_range(0, 15)) << 2;
            endcase
            if ($urandom_range(0, 199) == 0) begin
                #3;
                rst_n = 1'b0;
            end
            step();
            rst_n = 1'b1;
        end

        ready_i = 1'b0;
        halt_i = 1'b0;
        redirect_i = 1'b0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Initiator side of the instruction-memory interface. Owns the program counter and drives the word-aligned byte address to instr_mem. The memory returns data combinationally, and the block captures it into a small prefetch FIFO. It presents {pc, instr} to decode over a valid/ready handshake, and handles branch/jump redirects and halts.

Parameters:
DATA_WIDTH, 32, width of PC, address and instruction.
FIFO_DEPTH, 2, prefetch entries; power of two, >= 2.
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_addr_o  output  DATA_WIDTH  byte address to instruction memory (equals pc_q)
imem_instr_i  input  DATA_WIDTH  instruction returned same cycle for imem_addr_o
halt_i  input  1  suppress new fetches; the FIFO still drains
redirect_i  input  1  one-cycle pulse: flush and restart at redirect_pc_i
redirect_pc_i  input  DATA_WIDTH  target byte address
instr_o  output  DATA_WIDTH  instruction at FIFO head
pc_o  output  DATA_WIDTH  PC of instr_o
valid_o  output  1  head entry valid
ready_i  input  1  decode accepts head this cycle
count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - pc_q = RESET_PC; FIFO empty.
  - valid_o=0, count_o=0, instr_o=32'h00000013 (NOP), pc_o=RESET_PC, imem_addr_o=RESET_PC.
- Reset mid-operation discards all entries immediately, with no glitch on valid_o after deassertion.
- imem_addr_o = pc_q at all times; there is no combinational path from any input to imem_addr_o.
- pop = valid_o && ready_i.
- push = !redirect_i && !halt_i && (count < FIFO_DEPTH || pop).
  - Push writes {pc_q, imem_instr_i} at the tail.
  - pc_q <= pc_q + 4, modulo 2^DATA_WIDTH (32'hFFFF_FFFC wraps to 0).
- Full and pop in the same cycle: push is still allowed and count is unchanged.
- Empty: valid_o=0 and outputs hold the NOP/last-PC values; ready_i is ignored.
- Redirect has priority over everything:
  - FIFO flushed (count=0) and no push that cycle.
  - pc_q <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}; misaligned low bits are silently cleared.
  - A pop coinciding with a redirect is still counted as accepted by decode; the flush removes the rest.
- Halt: pc_q holds and no push occurs; pops continue. Redirect during halt still updates pc_q.
- Latency: the instruction at the address in pc_q is visible at the FIFO head one cycle after the push edge. From reset release, the first valid_o=1 appears after the first clk edge.
- Steady state with ready_i=1 and no halt: one instruction per cycle, PC sequence +4.
- Registered outputs: instr_o, pc_o, valid_o and count_o come from FIFO storage/pointers only.
- FIFO structure:
  - Read/write pointers of $clog2(FIFO_DEPTH) bits wrap naturally.
  - A separate occupancy counter distinguishes full from empty.
- Assertions in SIMULATION:
  - count_o never exceeds FIFO_DEPTH.
  - pc_q[1:0]==0 always.
  - No push while full without a pop.

Decomposition:
- Shared package core_pkg:
  - RESET_PC_DEFAULT and NOP_INSTR (32'h00000013) constants.
  - fetch_entry_t packed struct {pc, instr}.
- Sub-module fetch_fifo: parameterised on depth and element type fetch_entry_t, with push/pop/flush and count. It is reusable for future decode skid buffers.
- PC/redirect/halt logic stays in instr_fetch.

Test Plan:
1. Reset then ready_i=1, memory preloaded with the standard 10-word program -> pc_o 0,4,8,... on consecutive cycles; instr_o 00100093, 00200113, 002081b3; valid_o=1 from the first cycle after the first edge.
2. ready_i=0 for 5 cycles after reset -> count_o reaches 2 and saturates, pc_q=8, imem_addr_o stays 8. Then ready_i=1 -> entries at pc 0 and 4 delivered, then 8, with no drop or duplicate.
3. redirect_i with redirect_pc_i=32'h20 while FIFO is full -> next cycle count_o=0, valid_o=0, imem_addr_o=0x20. The following cycle pc_o=0x20.
4. redirect_pc_i=32'h0000_0013 -> fetch resumes at 0x10; pc_o=0x10 delivers instruction 00a27293.
5. Redirect to 32'hFFFF_FFFC with ready_i=1 -> pc_o=FFFF_FFFC, then 0 on the next instruction (wrap).
6. halt_i=1 with 2 entries queued and ready_i=1 -> both drain, then valid_o=0 and pc_q frozen. rst_n asserted mid-drain -> valid_o=0 immediately (asynchronous) and pc returns to RESET_PC.
